// File: rtl/eth_axis_pkg.sv
// eth_axis_pkg: shared FSM encoding, arbitration mode names and index-width helper for the TX arbiter
package eth_axis_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
  localparam string ARB_RR   = "ROUND_ROBIN";
  localparam string ARB_PRIO = "PRIORITY";
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/eth_rr_arbiter.sv
// eth_rr_arbiter: picks one requester, either round-robin after last_i or lowest index first
module eth_rr_arbiter
  import eth_axis_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IW-1:0]       last_i,
  input  logic                prio_i,
  output logic                valid_o,
  output logic [CHANNELS-1:0] gnt_o,
  output logic [IW-1:0]       idx_o
);
  logic found;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      automatic int c = prio_i ? k : (int'(last_i) + 1 + k) % CHANNELS;
      if (!found && req_i[c]) begin
        found = 1'b1;
        idx_o = IW'(c);
      end
    end
  end
  assign valid_o = found;
  assign gnt_o   = found ? CHANNELS'(1) << idx_o : '0;
endmodule

// File: rtl/eth_axis_tx_arb.sv
// eth_axis_tx_arb: frame-locked N:1 AXI-Stream TX arbiter with one output register stage and idle timeout abort
module eth_axis_tx_arb
  import eth_axis_pkg::*;
#(
  parameter int    CHANNELS       = 4,
  parameter int    DATA_WIDTH     = 8,
  parameter string ARB_MODE       = ARB_RR,
  parameter int    TIMEOUT_CYCLES = 1024,
  localparam int   IW             = idx_w(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS-1:0]            s_axis_tuser,
  output logic [CHANNELS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic                           grant_valid,
  output logic [IW-1:0]                  grant_index,
  output logic                           frame_abort
);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  localparam bit PRIO  = ARB_MODE == ARB_PRIO;
  state_t                state_q;
  logic [IW-1:0]         last_q, idx_q, arb_idx;
  logic [CHANNELS-1:0]   gnt_q, arb_gnt;
  logic [31:0]           cnt_q;
  logic [DATA_WIDTH-1:0] m_data_q, sd;
  logic                  m_valid_q, m_last_q, m_user_q, abort_q;
  logic                  arb_valid, out_rdy, sv, sl, su;
  eth_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req_i   (s_axis_tvalid),
    .last_i  (last_q),
    .prio_i  (PRIO),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx)
  );
  assign out_rdy       = !m_valid_q || m_axis_tready;
  assign sv            = |(s_axis_tvalid & gnt_q);
  assign sl            = |(s_axis_tlast & gnt_q);
  assign su            = |(s_axis_tuser & gnt_q);
  assign sd            = s_axis_tdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign s_axis_tready = ((state_q == PASS) && out_rdy) || (state_q == DRAIN) ? gnt_q : '0;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign grant_valid   = state_q != IDLE;
  assign grant_index   = idx_q;
  assign frame_abort   = abort_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= IW'(CHANNELS - 1);
      idx_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (m_axis_tready) m_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (arb_valid) begin
          state_q <= PASS;
          idx_q   <= arb_idx;
          last_q  <= arb_idx;
          gnt_q   <= arb_gnt;
          cnt_q   <= '0;
        end
        PASS: if (sv && out_rdy) begin
          m_data_q  <= sd;
          m_valid_q <= 1'b1;
          m_last_q  <= sl;
          m_user_q  <= su;
          cnt_q     <= '0;
          if (sl) state_q <= IDLE;
        end else if (!sv && out_rdy && TO_EN) begin
          if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            // terminate the frame towards the MAC with an errored last beat
            m_data_q  <= '0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b1;
            m_user_q  <= 1'b1;
            abort_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DRAIN: if (sv && sl) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_axis_tx_arb.sv
// tb_eth_axis_tx_arb: scoreboard bench for the TX arbiter, round-robin and priority instances
module tb_eth_axis_tx_arb;
  import eth_axis_pkg::*;
  localparam int CH = 4, DW = 8;
  typedef struct { logic [DW-1:0] d; logic l; logic u; int gap; } beat_t;
  typedef struct { int ch; int len; int upos; bit tog; int lat; } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [CH*DW-1:0] s_tdata = '0;
  logic [CH-1:0] s_tvalid = '0, s_tlast = '0, s_tuser = '0, r_tready, p_tready, s_tready;
  logic [DW-1:0] r_mdata, p_mdata, m_data;
  logic r_mv, r_ml, r_mu, r_gv, r_ab, p_mv, p_ml, p_mu, p_gv, p_ab;
  logic m_valid, m_last, m_user, gv, ab;
  logic m_tready = 1'b1;
  logic [1:0] r_gi, p_gi, gi;
  bit sel = 1'b0, toggle = 1'b0, stalled = 1'b0;
  logic [DW+2:0] hold_v;
  beat_t srcq[CH][$];
  beat_t sb[$];
  int ncmp = 0, nfail = 0, cyc = 0, nout = 0, abort_cnt = 0, first_out = -1, first_valid = -1;
  vec_t vt[4];
  eth_axis_tx_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .ARB_MODE("ROUND_ROBIN"), .TIMEOUT_CYCLES(1024)) u_rr (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(r_tready), .m_axis_tdata(r_mdata), .m_axis_tvalid(r_mv),
    .m_axis_tlast(r_ml), .m_axis_tuser(r_mu), .m_axis_tready(m_tready), .grant_valid(r_gv),
    .grant_index(r_gi), .frame_abort(r_ab));
  eth_axis_tx_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .ARB_MODE("PRIORITY"), .TIMEOUT_CYCLES(1024)) u_pr (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(p_tready), .m_axis_tdata(p_mdata), .m_axis_tvalid(p_mv),
    .m_axis_tlast(p_ml), .m_axis_tuser(p_mu), .m_axis_tready(m_tready), .grant_valid(p_gv),
    .grant_index(p_gi), .frame_abort(p_ab));
  assign s_tready = sel ? p_tready : r_tready;
  assign m_data   = sel ? p_mdata : r_mdata;
  assign m_valid  = sel ? p_mv : r_mv;
  assign m_last   = sel ? p_ml : r_ml;
  assign m_user   = sel ? p_mu : r_mu;
  assign gv       = sel ? p_gv : r_gv;
  assign gi       = sel ? p_gi : r_gi;
  assign ab       = sel ? p_ab : r_ab;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic present();
    for (int c = 0; c < CH; c++) begin
      automatic bit v = srcq[c].size() > 0 && srcq[c][0].gap == 0;
      s_tvalid[c] = v;
      s_tdata[c*DW +: DW] = v ? srcq[c][0].d : '0;
      s_tlast[c] = v && srcq[c][0].l;
      s_tuser[c] = v && srcq[c][0].u;
      if (v && first_valid < 0) first_valid = cyc;
    end
  endtask
  task automatic clear_all();
    for (int c = 0; c < CH; c++) srcq[c].delete();
    sb.delete();
    present();
    nout = 0; abort_cnt = 0; first_out = -1; first_valid = -1; stalled = 1'b0;
  endtask
  task automatic do_reset(input bit s);
    @(posedge clk); #2;
    rst = 1'b1; sel = s; toggle = 1'b0; m_tready = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic load(input int c, input int len, input int base, input int gap_at, input int gap, input int upos);
    for (int i = 0; i < len; i++) begin
      automatic beat_t b;
      b.d = DW'((c << 6) | ((base + i) & 63));
      b.l = i == len - 1;
      b.u = i == upos;
      b.gap = i == gap_at ? gap : 0;
      srcq[c].push_back(b);
      if (gap_at < 0 || i < gap_at) sb.push_back(b);
    end
    present();
  endtask
  task automatic wait_done(input string name, input int lim);
    automatic int n = 0, pend = 0;
    while (n < lim) begin
      pend = sb.size();
      for (int c = 0; c < CH; c++) pend += srcq[c].size();
      if (pend == 0) break;
      @(posedge clk);
      n++;
    end
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_src_empty"}, pend, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask
  initial begin
    logic [CH-1:0] acc;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (acc[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
        else if (srcq[c].size() > 0 && srcq[c][0].gap > 0) begin
          automatic beat_t b = srcq[c][0];
          b.gap--;
          srcq[c][0] = b;
        end
      end
      m_tready = toggle ? ~m_tready : 1'b1;
      present();
    end
  end
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (stalled) chk("stable_while_stalled", {m_data, m_last, m_user, m_valid}, hold_v);
      stalled = m_valid && !m_tready;
      hold_v = {m_data, m_last, m_user, m_valid};
      if (ab) abort_cnt++;
      if (m_valid && first_out < 0) first_out = cyc;
      if (m_valid && m_tready) begin
        nout++;
        if (sb.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", {m_data, m_last, m_user}, cyc);
        end else begin
          e = sb.pop_front();
          chk("beat", {m_data, m_last, m_user}, {e.d, e.l, e.u});
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{0, 64, -1, 1'b0, 2};
    vt[1] = '{3, 1, 0, 1'b0, 2};
    vt[2] = '{1, 20, -1, 1'b1, 2};
    vt[3] = '{2, 5, 2, 1'b0, 2};
    repeat (2) @(negedge clk);
    chk("reset_rr_outputs", {r_mv, r_ml, r_mu, r_gv, r_ab, r_gi, r_mdata, r_tready}, 0);
    chk("reset_pr_outputs", {p_mv, p_ml, p_mu, p_gv, p_ab, p_gi, p_mdata, p_tready}, 0);
    foreach (vt[i]) begin
      do_reset(1'b0);
      @(posedge clk); #2;
      toggle = vt[i].tog;
      load(vt[i].ch, vt[i].len, 0, -1, 0, vt[i].upos);
      wait_done("vec", 200);
      chk("vec_latency", first_out - first_valid, vt[i].lat);
      chk("vec_count", nout, vt[i].len);
      chk("vec_no_abort", abort_cnt, 0);
    end
    do_reset(1'b0);
    @(posedge clk); #2;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) load(c, 3, 8 * r, -1, 0, c == 3 ? 2 : -1);
    wait_done("rr_order", 200);
    chk("rr_count", nout, 24);
    do_reset(1'b1);
    @(posedge clk); #2;
    for (int r = 0; r < 4; r++) load(0, 3, 8 * r, -1, 0, -1);
    for (int c = 1; c < CH; c++) load(c, 3, 0, -1, 0, -1);
    wait_done("prio_order", 200);
    chk("prio_count", nout, 21);
    do_reset(1'b0);
    @(posedge clk); #2;
    load(2, 20, 0, 10, 1100, -1);
    sb.push_back('{d: '0, l: 1'b1, u: 1'b1, gap: 0});
    repeat (3) @(posedge clk);
    #2;
    chk("timeout_grant", {gv, gi}, {1'b1, 2'd2});
    load(1, 4, 0, -1, 0, -1);
    wait_done("timeout", 1400);
    chk("abort_pulses", abort_cnt, 1);
    chk("timeout_count", nout, 15);
    do_reset(1'b0);
    @(posedge clk); #2;
    load(0, 20, 0, -1, 0, -1);
    for (int n = 0; n < 100 && nout < 5; n++) @(posedge clk);
    #2;
    chk("pre_rst_grant", gv, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {m_valid, m_last, m_user, m_data, gv, gi, ab, s_tready}, 0);
    clear_all();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    load(1, 8, 0, -1, 0, -1);
    wait_done("post_rst", 100);
    chk("post_rst_count", nout, 8);
    chk("post_rst_no_abort", abort_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/eth_axis_tx_arb.md
ETH_AXIS_TX_ARB -- requirements
Module: eth_axis_tx_arb

Interface
REQ-001 Parameter CHANNELS, default 4: number of client TX streams, range 1..16.
REQ-002 Parameter DATA_WIDTH, default 8: tdata width per channel, matching the MAC TX stream.
REQ-003 Parameter ARB_MODE, default "ROUND_ROBIN": "ROUND_ROBIN" or "PRIORITY" (lowest index wins).
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: consecutive granted-source idle cycles before abort; 0 disables the timeout.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_axis_tdata  input  CHANNELS*DATA_WIDTH  client data, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  CHANNELS each  per-channel AXI-Stream controls.
REQ-009 s_axis_tready  output  CHANNELS  per-channel ready.
REQ-010 m_axis_tdata  output  DATA_WIDTH; m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1 each  merged stream towards the MAC.
REQ-011 m_axis_tready  input  1  MAC-side ready.
REQ-012 grant_valid  output  1  high while a frame is granted; grant_index  output  $clog2(CHANNELS) (min 1)  granted channel.
REQ-013 frame_abort  output  1  one-cycle pulse when a timeout abort is issued.

Function
REQ-014 States: IDLE, PASS, DRAIN; reset state IDLE.
REQ-015 IDLE: any s_axis_tvalid high -> choose a winner, register grant, go to PASS next cycle; no beat is accepted in the arbitration cycle.
REQ-016 ROUND_ROBIN search starts at (last granted + 1) mod CHANNELS; after reset the last granted value is CHANNELS-1, so channel 0 wins first.
REQ-017 PRIORITY mode always selects the lowest-index requesting channel.
REQ-018 Grant is frame-locked: no re-arbitration until the granted channel's tlast beat is accepted.
REQ-019 PASS: s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready); all other tready bits are 0.
REQ-020 Output is a single register stage: an accepted beat appears on m_axis_* in the next cycle; latency is 1 cycle.
REQ-021 m_axis_* holds stable while m_axis_tvalid && !m_axis_tready.
REQ-022 Accepted tlast in PASS -> IDLE; grant_valid falls in the same edge.
REQ-023 Timeout counter: increments in PASS when s_axis_tvalid[g] is low and the output can accept; clears on any accepted beat; m_axis_tready stalls do not count.
REQ-024 On counter reaching TIMEOUT_CYCLES: load a beat with data 0, tlast 1 and tuser 1 into the output register, pulse frame_abort, then go to DRAIN.
REQ-025 DRAIN: s_axis_tready[g]=1; beats are discarded; the accepted tlast beat -> IDLE.
REQ-026 A client tuser on a passed beat is forwarded unchanged.
REQ-027 CHANNELS=1: the arbiter degenerates to a 1-cycle pipeline with timeout; grant_index is held at 0.

Reset
REQ-028 Asynchronous reset clears all outputs to 0, state to IDLE, the timeout counter to 0, and the RR pointer to CHANNELS-1.
REQ-029 Reset mid-frame drops the partial frame with no termination beat; release resumes in IDLE.

Structure
REQ-030 The state enum and ARB_MODE string constants live in the shared package eth_axis_pkg.
REQ-031 One sub-module, eth_rr_arbiter (CHANNELS-wide request vector -> one-hot and index, with mode input), handles selection; datapath and FSM stay in eth_axis_tx_arb.

Verification
REQ-032 Ch0 sends a 64-byte frame while m_axis_tready=1 -> 64 m beats identical to the source, tlast on beat 64, first beat 2 cycles after tvalid.
REQ-033 Ch0..3 each hold a 3-beat frame in ROUND_ROBIN -> output order 0,1,2,3 with no interleaving; repeated -> 0,1,2,3 again.
REQ-034 Same traffic in PRIORITY with ch0 re-requesting continuously -> ch0 frames only; ch3 starves.
REQ-035 Ch2 stalls 1024 cycles mid-frame after 10 beats (TIMEOUT_CYCLES=1024) -> beat 11 is data 0 with tlast=1 and tuser=1, frame_abort pulses once, the ch2 remainder is drained, then ch1 is granted.
REQ-036 m_axis_tready toggles 1/0 every cycle during a 20-beat frame -> no loss or duplication, no abort, output stable while stalled.
REQ-037 rst asserted at beat 5 of a frame -> all outputs 0 immediately; after release, a new ch1 frame passes intact.
